// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the FIR MAC sequencer.
// Contents: FSM state enum, sample/coefficient widths, accumulator width function.
// No ports; imported by fir_mac and fir_mac_sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  localparam int SAMPLE_W = 8;
  localparam int COEF_W   = 8;

  // Full-precision product plus enough headroom to sum `taps` products
  // without overflow.
  function automatic int acc_w(input int taps);
    return SAMPLE_W + COEF_W + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate: acc <= clr ? 0 : en ? acc + a*b : acc.
// Latency: one cycle from operands to updated acc_o. No backpressure (driven by the FSM).
// Ports: clk, rst (sync, active-high), clr_i, en_i, a_i/b_i (signed operands), acc_o.
module fir_mac
  import fir_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [SAMPLE_W-1:0] a_i,
  input  logic signed [COEF_W-1:0]   b_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [SAMPLE_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]           acc_q, acc_d;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      // Size cast of a signed value sign-extends the product.
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Direct-form FIR: one shared 8x8 MAC stepped over TAPS coefficients per accepted sample.
// Latency: sample accepted at edge 0, MAC on edges 1..TAPS, out_valid after edge TAPS.
// Backpressure: result held in OUT until out_ready; in_ready only in IDLE (state decode).
// Ports: clk, rst (sync, active-high); x/in_valid/in_ready sample input;
//   y/out_valid/out_ready result output; coef_we/coef_addr/coef_wdata coefficient load;
//   busy = FSM not idle.
// Option: define FIR_SAT_EN to saturate y to [-128,127]; otherwise y wraps.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS  = 4,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_W-1:0]     x,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [SAMPLE_W-1:0]     y,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_wdata,
  output logic                    busy
);

  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = acc_w(TAPS);

  fir_state_t                  state_q, state_d;
  logic [AW-1:0]               k_q, k_d;
  logic signed [SAMPLE_W-1:0]  dline_q [TAPS];
  logic signed [COEF_W-1:0]    coef_q  [TAPS];
  logic [SAMPLE_W-1:0]         y_hold_q;
  logic [SAMPLE_W-1:0]         y_narrow;
  logic signed [ACC_W-1:0]     acc;
  logic                        accept, mac_clr, mac_en, coef_wr;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    accept  = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          mac_clr = 1'b1;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == AW'(TAPS - 1)) begin
          k_d     = '0;
          state_d = OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A sample accept in the same cycle wins over a coefficient write.
  assign coef_wr = (state_q == IDLE) && coef_we && !in_valid &&
                   (32'(coef_addr) < TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      y_hold_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      // Capture the result while presenting it so y survives the handshake.
      if (state_q == OUT) y_hold_q <= y_narrow;
      if (accept) begin
        dline_q[0] <= x;
        for (int i = 1; i < TAPS; i++) dline_q[i] <= dline_q[i-1];
      end
      if (coef_wr) coef_q[coef_addr] <= coef_wdata;
    end
  end

  // ---------------- datapath ----------------
  fir_mac #(.ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (dline_q[k_q]),
    .b_i   (coef_q[k_q]),
    .acc_o (acc)
  );

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);
  logic signed [ACC_W-1:0] acc_shr;
  assign acc_shr = acc >>> SHIFT;
  always_comb begin
    y_narrow = acc_shr[SAMPLE_W-1:0];
    if (acc_shr > SAT_MAX)      y_narrow = 8'h7f;
    else if (acc_shr < SAT_MIN) y_narrow = 8'h80;
  end
`else
  assign y_narrow = SAMPLE_W'(acc >>> SHIFT);
`endif

  // acc is frozen in OUT, so y is stable there; elsewhere the last result is held.
  assign y         = (state_q == OUT) ? y_narrow : y_hold_q;
  assign out_valid = (state_q == OUT);
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

  localparam int TAPS = 4;
`ifdef FIR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic       coef_we;
  logic [1:0] coef_addr;
  logic [7:0] coef_wdata;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int last_y = 0;

  typedef struct {
    int x;
    int y;
  } vec_t;

  vec_t ms[5];
  vec_t imp[5];
  vec_t ov[4];
  vec_t zr[3];

  fir_mac_sequencer #(.TAPS(TAPS), .SHIFT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_y = 0;
  endtask

  task automatic set_coef(input int a, input int v);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 2'(a);
    coef_wdata = 8'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    set_coef(0, c0);
    set_coef(1, c1);
    set_coef(2, c2);
    set_coef(3, c3);
  endtask

  // Leaves the bench at the negedge just after the accept edge.
  task automatic send(input int xv, input string name);
    @(negedge clk);
    chk({name, "_in_ready"}, int'(in_ready), 1);
    x        = 8'(xv);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // start_n = edges already elapsed since the accept edge.
  task automatic wait_out(input int exp_y, input string name, input int start_n);
    int n;
    n = start_n;
    while (n < TAPS + 10) begin
      if (n > start_n) chk({name, "_y_held"}, int'($signed(y)), last_y);
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk({name, "_latency"}, n, TAPS);
    chk({name, "_y"}, int'($signed(y)), exp_y);
    chk({name, "_in_ready_low"}, int'(in_ready), 0);
    chk({name, "_busy"}, int'(busy), 1);
    last_y = exp_y;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    send(v.x, name);
    wait_out(v.y, name, 0);
  endtask

  initial begin
    ms[0] = '{1, 1};  ms[1] = '{2, 3};  ms[2] = '{3, 6};  ms[3] = '{4, 10}; ms[4] = '{5, 14};
    imp[0] = '{1, 1}; imp[1] = '{0, 2}; imp[2] = '{0, 3}; imp[3] = '{0, 4}; imp[4] = '{0, 0};
    // 127*127*n = 16129*n; low bytes of 0x3F01, 0x7E02, 0xBD03, 0xFC04 are 1..4.
    for (int i = 0; i < 4; i++) ov[i] = '{127, SAT ? 127 : i + 1};
    zr[0] = '{1, 0};  zr[1] = '{0, 0};  zr[2] = '{0, 0};

    rst = 1'b1; x = '0; in_valid = 1'b0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_y", int'(y), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;

    // Moving sum
    load_coefs(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) run_vec(ms[i], "movsum");

    // Impulse response from a clean delay line
    do_reset();
    load_coefs(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) run_vec(imp[i], "impulse");

    // Overflow of the 8-bit output
    load_coefs(127, 127, 127, 127);
    for (int i = 0; i < 4; i++) run_vec(ov[i], "overflow");

    // Backpressure: dline {1,127,127,127} -> 48514 = 0xBD82
    send(1, "bp");
    out_ready = 1'b0;
    wait_out(SAT ? 127 : -126, "bp", 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_out_valid", int'(out_valid), 1);
      chk("bp_hold_y", int'($signed(y)), last_y);
      chk("bp_hold_in_ready", int'(in_ready), 0);
      chk("bp_hold_busy", int'(busy), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_release_busy", int'(busy), 0);
    chk("bp_release_y_retained", int'($signed(y)), last_y);

    // Coefficient writes: ignored while busy, dropped on a same-cycle accept
    do_reset();
    set_coef(0, 1);
    send(5, "busywr");
    coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 8'd9;
    @(negedge clk);
    coef_we = 1'b0;
    wait_out(5, "busywr", 1);
    run_vec('{7, 7}, "busywr_next");
    set_coef(0, 9);
    run_vec('{2, 18}, "idlewr");
    @(negedge clk);
    x = 8'd1; in_valid = 1'b1;
    coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 8'd3;
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    wait_out(9, "dropwr", 0);
    run_vec('{1, 9}, "dropwr_next");

    // Reset in the middle of MAC
    send(3, "midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_y", int'(y), 0);
    last_y = 0;
    for (int i = 0; i < 3; i++) run_vec(zr[i], "midrst_zero");
    load_coefs(1, 2, 3, 4);
    run_vec('{0, 4}, "midrst_reload");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Controller that time-multiplexes one 8x8 signed multiply-accumulate unit across `TAPS` filter coefficients to run a direct-form FIR filter, one output per accepted input sample. It sits between the sample source and the sample sink. It owns the sample delay line, the coefficient register file and the MAC sequencing FSM, and exposes valid/ready handshakes on both sides plus a coefficient-load port for configuration.

## Interface
- `TAPS`, 4, number of coefficients/delay-line entries (2..16)
- `SHIFT`, 0, arithmetic right shift applied to the accumulator before output narrowing (0..15)
- `clk` input 1: sole clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `x` input 8: input sample, signed two's complement
- `in_valid` input 1: `x` is valid
- `in_ready` output 1: block accepts a sample this cycle
- `y` output 8: filtered sample, signed
- `out_valid` output 1: `y` is valid
- `out_ready` input 1: sink accepts `y`
- `coef_we` input 1: coefficient write strobe
- `coef_addr` input clog2(TAPS): coefficient index
- `coef_wdata` input 8: coefficient value, signed
- `busy` output 1: FSM is not in IDLE

## Operation
- FSM states: IDLE, MAC, OUT.
- IDLE behaviour:
  - `in_ready`=1.
  - On `in_valid&&in_ready`: `dline[0]<=x`, `dline[k]<=dline[k-1]`, `acc<=0`, `k<=0`, then go to MAC.
- MAC behaviour:
  - Each cycle: `acc<=acc+dline[k]*coef[k]` and `k<=k+1`.
  - After the cycle with `k==TAPS-1`, go to OUT.
- OUT behaviour:
  - `out_valid`=1 and `y` is held stable.
  - On `out_ready`, go to IDLE.
- Arithmetic:
  - Product is 16-bit signed.
  - `acc` is `16+clog2(TAPS)` bits, signed, and never overflows.
  - `y` is taken from `acc>>>SHIFT` and narrowed to 8 bits (see Configuration).
- Coefficient writes:
  - Accepted only in IDLE, and only when no sample is accepted in the same cycle. A write in that cycle is dropped.
  - A write while `busy`=1 is ignored. No error is flagged.
  - `coef_addr>=TAPS` is ignored.
- Reset:
  - Delay line, coefficients, `acc` and `k` are cleared to 0. State goes to IDLE.
  - Reset asserted mid-MAC or in OUT aborts the computation. No output is produced.
- Output values at reset: `in_ready`=1, `out_valid`=0, `y`=0, `busy`=0.

## Timing
- Sample accepted at edge 0.
- MAC cycles occupy edges 1..TAPS.
- `out_valid` is high from cycle TAPS+1.
- Minimum throughput is one sample per TAPS+2 cycles, with `out_ready` tied high.
- `in_ready` and `out_valid` are never high in the same cycle.
- `y` changes only on entry to OUT.
- `y` retains its last value after the OUT handshake until the next result.
- `in_ready` is a registered function of state only. It has no combinational path from `out_ready`.

## Configuration
- `FIR_SAT_EN` defined:
  - The shifted accumulator saturates to the range [-128, 127].
- `FIR_SAT_EN` undefined:
  - `y` is the low 8 bits of the shifted accumulator (wrap-around).
  - No saturation logic is synthesized.

## Structure
- Shared package `fir_pkg` holds:
  - the FSM state enum `fir_state_t` (IDLE, MAC, OUT);
  - `SAMPLE_W`=8 and `COEF_W`=8;
  - the accumulator-width function `acc_w(TAPS)`.
- One sub-module, `fir_mac`:
  - registered multiply-accumulate with `clr` and `en` inputs;
  - instantiated once.
- The FSM, delay line and coefficient file stay in `fir_mac_sequencer`.

## Test plan
- Moving sum: TAPS=4, SHIFT=0, coefficients {1,1,1,1}, inputs 1,2,3,4,5 -> `y`=1,3,6,10,14. Each result appears TAPS+1 cycles after its accept.
- Impulse: coefficients {1,2,3,4}, inputs 1,0,0,0,0 -> `y`=1,2,3,4,0.
- Overflow: coefficients all 127, four inputs of 127, SHIFT=0 -> accumulator 64516.
  - With `FIR_SAT_EN`: `y`=127.
  - Without: `y`=4.
- Backpressure: hold `out_ready`=0 for 5 cycles in OUT -> `out_valid` and `y` stable, `in_ready`=0, `busy`=1. The result is released on the first cycle `out_ready`=1.
- Coefficient write while busy: write coefficient 0 to 9 during MAC -> ignored, and the current and next outputs use the old value. A write issued in IDLE takes effect on the next sample.
- Reset mid-MAC: assert `rst` at MAC cycle 2 -> next cycle `busy`=0, `in_ready`=1, `out_valid`=0, `y`=0. The following impulse yields all-zero output until coefficients are reloaded.
